// File: rtl/freq_div.sv
// -----------------------------------------------------------------------------
// freq_div
// -----------------------------------------------------------------------------
// Converts one gate measurement from the reciprocal counter into a fixed-point
// signal frequency:
//     freq = (sig_cnt * REF_FREQ_HZ * 2^FRAC_BITS) / ref_cnt
// The scaled numerator is formed in one cycle (MUL), then a restoring divider
// produces one quotient bit per cycle, MSB first (DIV), and the result is
// presented for one cycle (DONE). A one-deep pending buffer holds a sample
// that arrives while the divider is busy.
//
// Optional build feature:
//   FREQ_DIV_ROUND_EN  - when defined, ref_cnt/2 is added to the numerator so
//                        the quotient is rounded half-up. The internal width
//                        NW and the divide length grow by one bit/cycle.
//                        When undefined the quotient truncates toward zero.
//
// Ports:
//   clk_i           reference clock
//   rst_n_i         asynchronous reset, active-low
//   data_valid_i    one-cycle strobe qualifying data_i
//   data_i[63:0]    [63:32] ref_cnt, [31:0] sig_cnt
//   clear_i         synchronous abort: back to IDLE, pending buffer and
//                   overrun flag cleared, result registers kept
//   busy_o          high whenever the FSM is not IDLE
//   result_valid_o  one-cycle strobe; result outputs valid in the same cycle
//   freq_o[63:0]    unsigned quotient with FRAC_BITS fractional bits
//   sig_cnt_o       sig_cnt of the sample behind the current result
//   ref_cnt_o       ref_cnt of the sample behind the current result
//   div_zero_o      current result came from ref_cnt == 0
//   sat_o           current result saturated to all-ones
//   overrun_o       sticky: a pending sample was overwritten
// -----------------------------------------------------------------------------
module freq_div #(
    parameter logic [31:0] REF_FREQ_HZ = 32'd100000000,
    parameter int unsigned FRAC_BITS   = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        data_valid_i,
    input  logic [63:0] data_i,
    input  logic        clear_i,
    output logic        busy_o,
    output logic        result_valid_o,
    output logic [63:0] freq_o,
    output logic [31:0] sig_cnt_o,
    output logic [31:0] ref_cnt_o,
    output logic        div_zero_o,
    output logic        sat_o,
    output logic        overrun_o
);

`ifdef FREQ_DIV_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    localparam int NW    = 64 + int'(FRAC_BITS) + int'(ROUND_EN);
    localparam int CNT_W = $clog2(NW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Scaled numerator. sig_cnt * REF_FREQ_HZ is at most 64 bits, so after the
    // FRAC_BITS shift (and optional half-divisor bias) it always fits in NW.
    function automatic logic [NW-1:0] scale_num(input logic [31:0] sig,
                                                input logic [31:0] rf);
        logic [63:0]   prod;
        logic [NW-1:0] n;
        prod = 64'(sig) * 64'(REF_FREQ_HZ);
        n    = NW'(prod) << FRAC_BITS;
        n    = n + (ROUND_EN ? NW'(rf >> 1) : '0);
        return n;
    endfunction

    // Clamp the NW-bit quotient to 64 bits; returns {sat, freq}.
    function automatic logic [64:0] sat_freq(input logic [NW-1:0] q);
        logic [NW-1:0] hi;
        hi = q >> 64;
        if (|hi) begin
            return {1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        end
        return {1'b0, q[63:0]};
    endfunction

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic            pend_full_q;
    logic [63:0]     pend_data_q;
    logic [31:0]     cur_sig_q, cur_ref_q;
    logic [NW-1:0]   num_q, quo_q;
    logic [NW:0]     rem_q;

    logic            load;
    logic [63:0]     load_data;
    logic            pend_wr;
    logic            enter_done;
    logic [NW:0]     rem_sh, rem_next;
    logic [NW:0]     den_ext;
    logic            q_bit;
    logic [NW-1:0]   quo_next;
    logic [64:0]     sat_res;

    assign busy_o         = (state_q != IDLE);
    assign result_valid_o = (state_q == DONE);

    // ---- next-state / load selection ----
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        load_data = data_i;
        case (state_q)
            IDLE: begin
                // A waiting sample is older than anything on data_i, so it goes first.
                if (pend_full_q) begin
                    load      = 1'b1;
                    load_data = pend_data_q;
                    state_d   = MUL;
                end else if (data_valid_i) begin
                    load    = 1'b1;
                    state_d = MUL;
                end
            end
            MUL:     state_d = (cur_ref_q == '0) ? DONE : DIV;
            DIV:     state_d = (cnt_q == '0) ? DONE : DIV;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear_i) begin
            state_d = IDLE;
            load    = 1'b0;
        end
    end

    // Any strobe that is not taken directly by IDLE lands in the pending buffer.
    assign pend_wr    = data_valid_i && !clear_i && ((state_q != IDLE) || pend_full_q);
    assign enter_done = (state_d == DONE) && (state_q != DONE);

    // ---- restoring divide step ----
    always_comb begin
        den_ext  = (NW+1)'(cur_ref_q);
        rem_sh   = (rem_q << 1) | (NW+1)'(num_q[NW-1]);
        q_bit    = (rem_sh >= den_ext);
        rem_next = q_bit ? (rem_sh - den_ext) : rem_sh;
        quo_next = (quo_q << 1) | NW'(q_bit);
        sat_res  = sat_freq(quo_next);
    end

    // ---- control registers and results ----
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_full_q <= 1'b0;
            overrun_o   <= 1'b0;
            freq_o      <= '0;
            sig_cnt_o   <= '0;
            ref_cnt_o   <= '0;
            div_zero_o  <= 1'b0;
            sat_o       <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_q == MUL) begin
                cnt_q <= CNT_W'(NW - 1);
            end else if (state_q == DIV) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end

            if (clear_i) begin
                pend_full_q <= 1'b0;
                overrun_o   <= 1'b0;
            end else if (pend_wr) begin
                pend_full_q <= 1'b1;
                // In IDLE the old pending sample is being consumed, so it is not lost.
                if (pend_full_q && (state_q != IDLE)) begin
                    overrun_o <= 1'b1;
                end
            end else if ((state_q == IDLE) && pend_full_q) begin
                pend_full_q <= 1'b0;
            end

            if (enter_done) begin
                sig_cnt_o <= cur_sig_q;
                ref_cnt_o <= cur_ref_q;
                if (state_q == MUL) begin
                    freq_o     <= '1;
                    div_zero_o <= 1'b1;
                    sat_o      <= 1'b0;
                end else begin
                    freq_o     <= sat_res[63:0];
                    div_zero_o <= 1'b0;
                    sat_o      <= sat_res[64];
                end
            end
        end
    end

    // ---- datapath registers ----
    always_ff @(posedge clk_i) begin
        if (pend_wr) begin
            pend_data_q <= data_i;
        end
        if (load) begin
            cur_sig_q <= load_data[31:0];
            cur_ref_q <= load_data[63:32];
        end
        if (state_q == MUL) begin
            num_q <= scale_num(cur_sig_q, cur_ref_q);
            rem_q <= '0;
            quo_q <= '0;
        end else if (state_q == DIV) begin
            num_q <= num_q << 1;
            rem_q <= rem_next;
            quo_q <= quo_next;
        end
    end

endmodule

// File: tb/tb_freq_div.sv
module tb_freq_div;

    localparam logic [31:0] REF_HZ = 32'd100000000;
    localparam int          FRAC   = 8;
`ifdef FREQ_DIV_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif
    localparam int NW = 64 + FRAC + int'(RND);

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        data_valid_i;
    logic [63:0] data_i;
    logic        clear_i;
    logic        busy_o;
    logic        result_valid_o;
    logic [63:0] freq_o;
    logic [31:0] sig_cnt_o;
    logic [31:0] ref_cnt_o;
    logic        div_zero_o;
    logic        sat_o;
    logic        overrun_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    freq_div #(
        .REF_FREQ_HZ (REF_HZ),
        .FRAC_BITS   (FRAC)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .data_valid_i   (data_valid_i),
        .data_i         (data_i),
        .clear_i        (clear_i),
        .busy_o         (busy_o),
        .result_valid_o (result_valid_o),
        .freq_o         (freq_o),
        .sig_cnt_o      (sig_cnt_o),
        .ref_cnt_o      (ref_cnt_o),
        .div_zero_o     (div_zero_o),
        .sat_o          (sat_o),
        .overrun_o      (overrun_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic straight from the frequency formula.
    task automatic model(input logic [31:0] rf, input logic [31:0] sg,
                         output logic [63:0] f, output logic dz, output logic sat);
        logic [127:0] num, q;
        if (rf == 32'd0) begin
            f = '1; dz = 1'b1; sat = 1'b0;
            return;
        end
        num = {96'd0, sg} * {96'd0, REF_HZ};
        num = num * (128'd1 << FRAC);
        if (RND) num = num + {96'd0, rf} / 128'd2;
        q   = num / {96'd0, rf};
        dz  = 1'b0;
        if (q > 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF) begin
            sat = 1'b1; f = '1;
        end else begin
            sat = 1'b0; f = q[63:0];
        end
    endtask

    // Called on a falling edge: strobe one sample, wait for its result, compare.
    task automatic run_one(input string tag, input logic [31:0] rf, input logic [31:0] sg);
        int          lat;
        int          exp_lat;
        logic [63:0] ef;
        logic        edz, esat;
        data_i       = {rf, sg};
        data_valid_i = 1'b1;
        lat = 0;
        forever begin
            @(negedge clk_i);
            data_valid_i = 1'b0;
            lat++;
            if (result_valid_o) break;
            if (lat >= NW + 20) begin
                lat = -1;
                break;
            end
        end
        exp_lat = (rf == 32'd0) ? 2 : NW + 2;
        model(rf, sg, ef, edz, esat);
        check_eq({tag, "_lat"},  64'(lat), 64'(exp_lat));
        check_eq({tag, "_freq"}, freq_o, ef);
        check_eq({tag, "_dz"},   64'(div_zero_o), 64'(edz));
        check_eq({tag, "_sat"},  64'(sat_o), 64'(esat));
        check_eq({tag, "_sig"},  64'(sig_cnt_o), 64'(sg));
        check_eq({tag, "_ref"},  64'(ref_cnt_o), 64'(rf));
        @(negedge clk_i);
        check_eq({tag, "_pulse"}, 64'({result_valid_o, busy_o}), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] ef, prev_freq;
        logic [31:0] prev_sig;
        logic        edz, esat;
        int          got;
        int          res_cyc [2];
        logic [31:0] res_sig [2];
        logic [63:0] res_freq[2];
        int          seen;
        logic [31:0] rf, sg;

        rst_n_i = 1'b0; data_valid_i = 1'b0; data_i = '0; clear_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_eq("rst_freq", freq_o, 64'd0);
        check_eq("rst_cnts", {sig_cnt_o, ref_cnt_o}, 64'd0);
        check_eq("rst_flags", 64'({busy_o, result_valid_o, div_zero_o, sat_o, overrun_o}), 64'd0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // Directed cases
        run_one("tp_nominal", 32'd100000000, 32'd1000);
        check_eq("tp_nominal_const", freq_o, 64'd256000);
        run_one("tp_third", 32'd3, 32'd2);
        check_eq("tp_third_const", freq_o, RND ? 64'd17066666667 : 64'd17066666666);
        run_one("tp_divzero", 32'd0, 32'd5);
        run_one("tp_sat", 32'd1, 32'hFFFF_FFFF);
        check_eq("tp_sat_const", 64'({sat_o, div_zero_o}), 64'b10);

        // A at c=0, B at c=1, C at c=5: B is overwritten by C
        data_i = {32'd100000000, 32'd1000}; data_valid_i = 1'b1;
        got = 0;
        for (int c = 1; c <= 2 * NW + 20; c++) begin
            @(negedge clk_i);
            if (result_valid_o && got < 2) begin
                res_cyc[got]  = c;
                res_sig[got]  = sig_cnt_o;
                res_freq[got] = freq_o;
                got++;
            end
            data_valid_i = (c == 1) || (c == 5);
            data_i = (c == 1) ? {32'd100000000, 32'd2000} : {32'd100000000, 32'd3000};
        end
        check_eq("ovr_count", 64'(got), 64'd2);
        check_eq("ovr_a_cyc", 64'(res_cyc[0]), 64'(NW + 2));
        check_eq("ovr_a_sig", 64'(res_sig[0]), 64'd1000);
        check_eq("ovr_a_freq", res_freq[0], 64'd256000);
        check_eq("ovr_c_cyc", 64'(res_cyc[1]), 64'(2 * NW + 5));
        check_eq("ovr_c_sig", 64'(res_sig[1]), 64'd3000);
        check_eq("ovr_c_freq", res_freq[1], 64'd768000);
        check_eq("ovr_flag", 64'(overrun_o), 64'd1);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        check_eq("ovr_cleared", 64'(overrun_o), 64'd0);

        // Asynchronous reset during the divide
        data_i = {32'd100000000, 32'd1234}; data_valid_i = 1'b1;
        seen = 0;
        for (int c = 1; c <= NW + 20; c++) begin
            @(negedge clk_i);
            data_valid_i = 1'b0;
            if (result_valid_o) seen++;
            if (c == 31) begin
                check_eq("rst_mid_freq", freq_o, 64'd0);
                check_eq("rst_mid_cnts", {sig_cnt_o, ref_cnt_o}, 64'd0);
                check_eq("rst_mid_busy", 64'({busy_o, overrun_o}), 64'd0);
            end
            if (c == 30) rst_n_i = 1'b0;
            if (c == 35) rst_n_i = 1'b1;
        end
        check_eq("rst_mid_novalid", 64'(seen), 64'd0);
        run_one("after_rst", 32'd50000000, 32'd777);

        // clear_i during the divide; a strobe in the clear cycle is dropped
        prev_freq = freq_o;
        prev_sig  = sig_cnt_o;
        data_i = {32'd100000000, 32'd4242}; data_valid_i = 1'b1;
        seen = 0;
        for (int c = 1; c <= NW + 20; c++) begin
            @(negedge clk_i);
            data_valid_i = 1'b0;
            clear_i      = 1'b0;
            if (result_valid_o) seen++;
            if (c == 31) begin
                check_eq("clr_idle", 64'(busy_o), 64'd0);
                check_eq("clr_hold_freq", freq_o, prev_freq);
                check_eq("clr_hold_sig", 64'(sig_cnt_o), 64'(prev_sig));
            end
            if (c == 32) check_eq("clr_drop_strobe", 64'(busy_o), 64'd0);
            if (c == 30) begin
                clear_i      = 1'b1;
                data_valid_i = 1'b1;
                data_i       = {32'd0, 32'd9};
            end
        end
        check_eq("clr_novalid", 64'(seen), 64'd0);

        // Randomized samples against the model
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: begin rf = 32'd0;                   sg = $urandom; end
                1: begin rf = $urandom_range(1, 15);   sg = $urandom; end
                2: begin rf = $urandom;                sg = $urandom; end
                default: begin
                    rf = REF_HZ - 32'd5000 + $urandom_range(0, 10000);
                    sg = $urandom_range(0, 1000000);
                end
            endcase
            run_one($sformatf("rnd%0d", i), rf, sg);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
